// File: rtl/ibex_scramble_key_fetch.sv
// ibex_scramble_key_fetch
//
// Fetches a scrambling key and nonce from OTP on behalf of the scramble key
// register. Each OTP response is screened: an all-zero or all-ones key, or a
// zero nonce, is rejected. Rejections are retried after a one-cycle backoff.
// Once MaxRetries rejections have accumulated, the block parks in a sticky
// error state that only rst_i clears.
//
// Configuration macro: IBEX_SCRAMBLE_TIMEOUT_EN
//   defined   : a request unanswered for TimeoutCycles cycles is treated as a
//               rejection. An ack arriving in the final cycle still wins.
//   undefined : the request waits for an ack indefinitely.
//
// Ports
//   clk_i                 in   clock; all logic on the rising edge
//   rst_i                 in   synchronous, active-high reset
//   scramble_req_i        in   level request from the scramble key register
//   otp_req_o             out  key request to OTP (high only while in REQ)
//   otp_ack_i             in   OTP response strobe; key/nonce valid while high
//   otp_key_i             in   OTP key data
//   otp_nonce_i           in   OTP nonce data
//   scramble_key_valid_o  out  one-cycle pulse when a new key is presented
//   scramble_key_o        out  last accepted key (registered)
//   scramble_nonce_o      out  last accepted nonce (registered)
//   busy_o                out  high in every state except IDLE and ERR
//   fetch_err_o           out  sticky fatal error
module ibex_scramble_key_fetch #(
  parameter int unsigned TimeoutCycles = 1023,
  parameter int unsigned MaxRetries    = 3,
  // Same values as ibex_pkg::SCRAMBLE_KEY_W / SCRAMBLE_NONCE_W.
  localparam int unsigned SCRAMBLE_KEY_W   = 128,
  localparam int unsigned SCRAMBLE_NONCE_W = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        scramble_req_i,
  output logic                        otp_req_o,
  input  logic                        otp_ack_i,
  input  logic [SCRAMBLE_KEY_W-1:0]   otp_key_i,
  input  logic [SCRAMBLE_NONCE_W-1:0] otp_nonce_i,
  output logic                        scramble_key_valid_o,
  output logic [SCRAMBLE_KEY_W-1:0]   scramble_key_o,
  output logic [SCRAMBLE_NONCE_W-1:0] scramble_nonce_o,
  output logic                        busy_o,
  output logic                        fetch_err_o
);

  // A zero-width counter is not representable, so MaxRetries = 0 still gets
  // one bit; with that setting the first rejection goes straight to ERR.
  localparam int unsigned RETRY_W = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MaxRetries);

  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("TimeoutCycles must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    BACKOFF = 3'd2,
    VALID   = 3'd3,
    ERR     = 3'd4
  } state_e;

  state_e             state;
  logic [RETRY_W-1:0] retry_cnt;

  // Saturating increment: the count holds at RETRY_MAX rather than wrapping.
  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] cnt);
    return (cnt == RETRY_MAX) ? cnt : cnt + RETRY_W'(1);
  endfunction

  logic               key_ok;
  logic               accept;
  logic               reject;
  logic               timeout_hit;
  logic [RETRY_W-1:0] retry_inc;
  logic               to_err;

  assign key_ok = (|otp_key_i) & ~(&otp_key_i) & (|otp_nonce_i);

`ifdef IBEX_SCRAMBLE_TIMEOUT_EN
  localparam int unsigned TIMEOUT_W = $clog2(TimeoutCycles + 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TimeoutCycles - 1);

  logic [TIMEOUT_W-1:0] timeout_cnt;

  // The counter reads k during the (k+1)-th REQ cycle, so TIMEOUT_LAST marks
  // the TimeoutCycles-th cycle. An ack in that cycle takes priority.
  assign timeout_hit = ~otp_ack_i & (timeout_cnt == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign accept    = otp_ack_i & key_ok;
  assign reject    = (otp_ack_i & ~key_ok) | timeout_hit;
  assign retry_inc = sat_inc(retry_cnt);
  assign to_err    = (retry_inc >= RETRY_MAX);

  // Outputs are registered alongside the state. Each one is assigned the
  // value that belongs to the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state                <= IDLE;
      retry_cnt            <= '0;
      otp_req_o            <= 1'b0;
      scramble_key_valid_o <= 1'b0;
      busy_o               <= 1'b0;
      fetch_err_o          <= 1'b0;
      scramble_key_o       <= '0;
      scramble_nonce_o     <= '0;
`ifdef IBEX_SCRAMBLE_TIMEOUT_EN
      timeout_cnt          <= '0;
`endif
    end else begin
      scramble_key_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (scramble_req_i) begin
            state     <= REQ;
            retry_cnt <= '0;
            otp_req_o <= 1'b1;
            busy_o    <= 1'b1;
`ifdef IBEX_SCRAMBLE_TIMEOUT_EN
            timeout_cnt <= '0;
`endif
          end
        end

        REQ: begin
          if (accept) begin
            state                <= VALID;
            otp_req_o            <= 1'b0;
            scramble_key_valid_o <= 1'b1;
            scramble_key_o       <= otp_key_i;
            scramble_nonce_o     <= otp_nonce_i;
          end else if (reject) begin
            retry_cnt <= retry_inc;
            otp_req_o <= 1'b0;
            if (to_err) begin
              state       <= ERR;
              busy_o      <= 1'b0;
              fetch_err_o <= 1'b1;
            end else begin
              state <= BACKOFF;
            end
          end
`ifdef IBEX_SCRAMBLE_TIMEOUT_EN
          else begin
            timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
          end
`endif
        end

        BACKOFF: begin
          state     <= REQ;
          otp_req_o <= 1'b1;
`ifdef IBEX_SCRAMBLE_TIMEOUT_EN
          timeout_cnt <= '0;
`endif
        end

        VALID: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end

        ERR: begin
          // Sticky until reset.
          state <= ERR;
        end

        default: begin
          state       <= IDLE;
          otp_req_o   <= 1'b0;
          busy_o      <= 1'b0;
          fetch_err_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ibex_scramble_key_fetch.md
IBEX_SCRAMBLE_KEY_FETCH -- requirements
Module: ibex_scramble_key_fetch

Interface
REQ-001 Parameters SHALL be: TimeoutCycles, default 1023, REQ-state cycles without ack before retry; MaxRetries, default 3, rejected/timed-out attempts tolerated before error.
REQ-002 Widths SHALL be SCRAMBLE_KEY_W=128 and SCRAMBLE_NONCE_W=64, taken from ibex_pkg.
REQ-003 Port: clk_i  in  1  sole clock, all logic on rising edge.
REQ-004 Port: rst_i  in  1  reset, synchronous and active-high.
REQ-005 Port: scramble_req_i  in  1  level key request from the scramble key register.
REQ-006 Port: otp_req_o  out  1  key request to OTP.
REQ-007 Port: otp_ack_i  in  1  OTP response strobe; key/nonce valid while high.
REQ-008 Port: otp_key_i  in  SCRAMBLE_KEY_W  OTP key data.
REQ-009 Port: otp_nonce_i  in  SCRAMBLE_NONCE_W  OTP nonce data.
REQ-010 Port: scramble_key_valid_o  out  1  one-cycle pulse to the key register.
REQ-011 Port: scramble_key_o  out  SCRAMBLE_KEY_W  registered accepted key.
REQ-012 Port: scramble_nonce_o  out  SCRAMBLE_NONCE_W  registered accepted nonce.
REQ-013 Port: busy_o  out  1  high in any state other than IDLE and ERR.
REQ-014 Port: fetch_err_o  out  1  sticky fatal error level.

Function
REQ-015 FSM states SHALL be IDLE, REQ, BACKOFF, VALID, ERR.
REQ-016 IDLE: scramble_req_i high -> REQ next cycle; retry counter cleared to 0.
REQ-017 REQ: otp_req_o SHALL be 1, held until a cycle with otp_ack_i high; otp_req_o 0 in every other state.
REQ-018 Ack in REQ: key/nonce sampled that cycle; accepted if key is neither all-zero nor all-ones and nonce is non-zero.
REQ-019 Accepted: scramble_key_o/scramble_nonce_o updated at that edge; VALID next cycle; scramble_key_valid_o high exactly one cycle (ack cycle N -> pulse N+1); then IDLE.
REQ-020 Rejected: key/nonce outputs unchanged; retry counter +1; BACKOFF if counter < MaxRetries, else ERR.
REQ-021 BACKOFF: exactly one cycle with otp_req_o low, then REQ.
REQ-022 otp_ack_i outside REQ SHALL be ignored, with no state or data change.
REQ-023 scramble_req_i falling while busy SHALL be ignored; the transaction completes.
REQ-024 ERR: fetch_err_o 1, otp_req_o 0, scramble_key_valid_o 0; left only by rst_i.
REQ-025 Retry counter width SHALL be $clog2(MaxRetries+1) and SHALL saturate, never wrap.
REQ-026 New request in the cycle after VALID SHALL be accepted from IDLE normally.

Reset
REQ-027 rst_i high at an edge: state IDLE; otp_req_o, scramble_key_valid_o, busy_o, fetch_err_o 0; scramble_key_o, scramble_nonce_o all-zero; counters 0.
REQ-028 Reset SHALL override every other event, including mid-REQ and same-cycle ack.

Configuration
REQ-029 Macro IBEX_SCRAMBLE_TIMEOUT_EN defined: REQ has a timeout counter, width $clog2(TimeoutCycles+1), cleared on REQ entry; TimeoutCycles consecutive REQ cycles without ack count as a rejection (REQ-020).
REQ-030 Ack in the same cycle the timeout is reached SHALL win; it is evaluated per REQ-018.
REQ-031 Macro undefined: no timeout counter; REQ waits indefinitely; TimeoutCycles unused.

Verification
REQ-032 Req high, ack after 5 cycles with key 0x1 and nonce 0x2 -> otp_req_o high 5 cycles; pulse one cycle later; key_o=0x1, nonce_o=0x2; back in IDLE.
REQ-033 Three all-zero-key acks -> BACKOFF between each with otp_req_o low 1 cycle; after 3rd, fetch_err_o=1 and no valid pulse; err persists until rst_i.
REQ-034 Two all-ones rejections, then a valid key -> single valid pulse; fetch_err_o stays 0.
REQ-035 With IBEX_SCRAMBLE_TIMEOUT_EN, TimeoutCycles=8, no ack -> otp_req_o drops after 8 cycles; ERR after 3 timeouts. Without the macro, otp_req_o stays high 2000 cycles.
REQ-036 rst_i asserted mid-REQ, and separately together with ack -> next cycle IDLE, all outputs at reset values, no valid pulse.
REQ-037 Ack injected in IDLE and in BACKOFF -> no state, output or data change.
